// File: rtl/sram_word_bridge_if.sv
// sram_word_bridge_if
//   Core-side request/response bundle for sram_word_bridge.
//   master : the requester (core memory stage)
//   slave  : the bridge
//   i_req    request valid, held by the requester until o_rdy
//   i_we     1 = write, 0 = read
//   i_addr   byte address, bits [1:0] ignored
//   i_wdata  write data
//   i_bmask  write byte enables, bit n = byte n
//   o_rdy    bridge can accept a request this cycle
//   o_done   one-cycle completion pulse
//   o_rdata  read word, held until the next read completes
interface sram_word_bridge_if;
   logic        i_req;
   logic        i_we;
   logic [31:0] i_addr;
   logic [31:0] i_wdata;
   logic [3:0]  i_bmask;
   logic        o_rdy;
   logic        o_done;
   logic [31:0] o_rdata;

   modport master (
      output i_req, i_we, i_addr, i_wdata, i_bmask,
      input  o_rdy, o_done, o_rdata
   );

   modport slave (
      input  i_req, i_we, i_addr, i_wdata, i_bmask,
      output o_rdy, o_done, o_rdata
   );
endinterface

// File: rtl/sram_word_bridge.sv
// sram_word_bridge
//   Turns single 32-bit load/store requests into two timed half-word
//   accesses on a 16-bit asynchronous SRAM. Reads always fetch both halves;
//   writes honour a 4-bit byte mask and skip any half with no enabled bytes.
//
//   Parameters
//     T_PULSE   cycles WE_N/OE_N are held active per phase (>= 1)
//     ADDR_W    SRAM half-word address width
//   Ports
//     i_clk      system clock, rising edge
//     i_rst      synchronous reset, active-high
//     bus        request/response bundle (slave side)
//     SRAM_ADDR  half-word address
//     SRAM_DQ    bidirectional data, driven only during write phases
//     SRAM_CE_N, SRAM_WE_N, SRAM_OE_N, SRAM_LB_N, SRAM_UB_N  active-low strobes
//
//   state    | meaning
//   ---------+--------------------------------------------------------------
//   IDLE     | ready, waiting for i_req
//   LO_SETUP | low half: address/lanes/data set up, strobes not yet active
//   LO_ACT   | low half: WE_N (write) active for T_PULSE cycles, read sampled
//   LO_HOLD  | low half write: WE_N released, address/data held
//   HI_SETUP | high half: setup
//   HI_ACT   | high half: active pulse
//   HI_HOLD  | high half write: hold
//   DONE     | o_done pulse, strobes released, one cycle
module sram_word_bridge #(
   parameter int T_PULSE = 1,
   parameter int ADDR_W  = 18
) (
   input  logic                i_clk,
   input  logic                i_rst,
   sram_word_bridge_if.slave   bus,
   output logic [ADDR_W-1:0]   SRAM_ADDR,
   inout  wire  [15:0]         SRAM_DQ,
   output logic                SRAM_CE_N,
   output logic                SRAM_WE_N,
   output logic                SRAM_OE_N,
   output logic                SRAM_LB_N,
   output logic                SRAM_UB_N
);

   typedef enum logic [2:0] {
      IDLE,
      LO_SETUP,
      LO_ACT,
      LO_HOLD,
      HI_SETUP,
      HI_ACT,
      HI_HOLD,
      DONE
   } state_t;

   localparam int                CNT_W    = (T_PULSE > 1) ? $clog2(T_PULSE) : 1;
   localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(T_PULSE - 1);

   state_t              state;
   state_t              state_nxt;
   logic [CNT_W-1:0]    cnt;
   logic                act_tc;

   logic                req_we;
   logic [ADDR_W-2:0]   req_hw_addr;
   logic [31:0]         req_wdata;
   logic [3:0]          req_bmask;

   logic                cur_we;
   logic [ADDR_W-2:0]   cur_hw_addr;
   logic [31:0]         cur_wdata;
   logic [3:0]          cur_bmask;

   logic                nxt_lo;
   logic                nxt_hi;
   logic                nxt_phase;
   logic                nxt_act;

   logic [15:0]         dq_out;
   logic                dq_oe;
   logic [31:0]         rdata;
   logic                done;

   logic                unused_addr_bits;
   assign unused_addr_bits = ^{bus.i_addr[31:ADDR_W+1], bus.i_addr[1:0]};

   always_comb begin
      state_nxt = state;
      act_tc    = (cnt == '0);

      // Strobe registers for the first phase are loaded on the accept edge,
      // before the request latches hold anything, so use the live inputs then.
      cur_we      = req_we;
      cur_hw_addr = req_hw_addr;
      cur_wdata   = req_wdata;
      cur_bmask   = req_bmask;
      if (state == IDLE) begin
         cur_we      = bus.i_we;
         cur_hw_addr = bus.i_addr[ADDR_W:2];
         cur_wdata   = bus.i_wdata;
         cur_bmask   = bus.i_bmask;
      end

      case (state)
         IDLE: begin
            if (bus.i_req) begin
               if (!bus.i_we)                      state_nxt = LO_SETUP;
               else if (bus.i_bmask[1:0] != 2'b00) state_nxt = LO_SETUP;
               else if (bus.i_bmask[3:2] != 2'b00) state_nxt = HI_SETUP;
               else                                state_nxt = DONE;
            end
         end
         LO_SETUP: state_nxt = LO_ACT;
         LO_ACT: begin
            if (act_tc) state_nxt = req_we ? LO_HOLD : HI_SETUP;
         end
         LO_HOLD:  state_nxt = (req_bmask[3:2] != 2'b00) ? HI_SETUP : DONE;
         HI_SETUP: state_nxt = HI_ACT;
         HI_ACT: begin
            if (act_tc) state_nxt = req_we ? HI_HOLD : DONE;
         end
         HI_HOLD:  state_nxt = DONE;
         DONE:     state_nxt = IDLE;
         default:  state_nxt = IDLE;
      endcase

      nxt_lo    = (state_nxt == LO_SETUP) || (state_nxt == LO_ACT) || (state_nxt == LO_HOLD);
      nxt_hi    = (state_nxt == HI_SETUP) || (state_nxt == HI_ACT) || (state_nxt == HI_HOLD);
      nxt_phase = nxt_lo || nxt_hi;
      nxt_act   = (state_nxt == LO_ACT) || (state_nxt == HI_ACT);
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state       <= IDLE;
         cnt         <= '0;
         req_we      <= 1'b0;
         req_hw_addr <= '0;
         req_wdata   <= '0;
         req_bmask   <= '0;
         SRAM_ADDR   <= '0;
         SRAM_CE_N   <= 1'b1;
         SRAM_WE_N   <= 1'b1;
         SRAM_OE_N   <= 1'b1;
         SRAM_LB_N   <= 1'b1;
         SRAM_UB_N   <= 1'b1;
         dq_out      <= '0;
         dq_oe       <= 1'b0;
         rdata       <= '0;
         done        <= 1'b0;
      end else begin
         state <= state_nxt;

         if (state == IDLE && bus.i_req) begin
            req_we      <= bus.i_we;
            req_hw_addr <= bus.i_addr[ADDR_W:2];
            req_wdata   <= bus.i_wdata;
            req_bmask   <= bus.i_bmask;
         end

         // Pulse timer: loaded during SETUP, counts down through ACT.
         if (state == LO_SETUP || state == HI_SETUP)
            cnt <= CNT_LOAD;
         else if ((state == LO_ACT || state == HI_ACT) && !act_tc)
            cnt <= cnt - CNT_W'(1);

         // Read data is taken at the edge that ends the last ACT cycle,
         // while OE_N and the address are still applied.
         if (state == LO_ACT && act_tc && !req_we) rdata[15:0]  <= SRAM_DQ;
         if (state == HI_ACT && act_tc && !req_we) rdata[31:16] <= SRAM_DQ;

         // Pin registers follow the state being entered, so each pin
         // changes on the same edge as the state that owns it.
         SRAM_CE_N <= ~nxt_phase;
         SRAM_OE_N <= ~(nxt_phase && !cur_we);
         SRAM_WE_N <= ~(nxt_act && cur_we);
         SRAM_LB_N <= ~(nxt_phase && (!cur_we || (nxt_lo ? cur_bmask[0] : cur_bmask[2])));
         SRAM_UB_N <= ~(nxt_phase && (!cur_we || (nxt_lo ? cur_bmask[1] : cur_bmask[3])));
         if (nxt_phase) SRAM_ADDR <= {cur_hw_addr, nxt_hi};
         dq_oe  <= nxt_phase && cur_we;
         dq_out <= nxt_hi ? cur_wdata[31:16] : cur_wdata[15:0];

         done <= (state_nxt == DONE);
      end
   end

   assign SRAM_DQ     = dq_oe ? dq_out : 16'hzzzz;
   assign bus.o_rdy   = (state == IDLE) && !i_rst;
   assign bus.o_done  = done;
   assign bus.o_rdata = rdata;

endmodule

// File: tb/tb_sram_word_bridge.sv
// Directed bench for sram_word_bridge: one instance at T_PULSE = 1 and one
// at T_PULSE = 3, each with a small behavioural SRAM on its pins.
module tb_sram_word_bridge;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic        use3  = 1'b0;
   logic        req   = 1'b0;
   logic        we    = 1'b0;
   logic [31:0] addr  = '0;
   logic [31:0] wdata = '0;
   logic [3:0]  bmask = '0;

   sram_word_bridge_if bus1 ();
   sram_word_bridge_if bus3 ();

   assign bus1.i_req   = req && !use3;
   assign bus1.i_we    = we;
   assign bus1.i_addr  = addr;
   assign bus1.i_wdata = wdata;
   assign bus1.i_bmask = bmask;
   assign bus3.i_req   = req && use3;
   assign bus3.i_we    = we;
   assign bus3.i_addr  = addr;
   assign bus3.i_wdata = wdata;
   assign bus3.i_bmask = bmask;

   wire  [15:0] dq1, dq3;
   logic [17:0] a1, a3;
   logic        ce1, we1, oe1, lb1, ub1;
   logic        ce3, we3, oe3, lb3, ub3;

   sram_word_bridge #(.T_PULSE(1), .ADDR_W(18)) dut1 (
      .i_clk(clk), .i_rst(rst), .bus(bus1.slave),
      .SRAM_ADDR(a1), .SRAM_DQ(dq1), .SRAM_CE_N(ce1), .SRAM_WE_N(we1),
      .SRAM_OE_N(oe1), .SRAM_LB_N(lb1), .SRAM_UB_N(ub1)
   );

   sram_word_bridge #(.T_PULSE(3), .ADDR_W(18)) dut3 (
      .i_clk(clk), .i_rst(rst), .bus(bus3.slave),
      .SRAM_ADDR(a3), .SRAM_DQ(dq3), .SRAM_CE_N(ce3), .SRAM_WE_N(we3),
      .SRAM_OE_N(oe3), .SRAM_LB_N(lb3), .SRAM_UB_N(ub3)
   );

   // Behavioural SRAMs: read drives while CE_N/OE_N low, write per lane while WE_N low.
   logic [15:0] mem1 [0:255];
   logic [15:0] mem3 [0:255];
   assign dq1 = (!ce1 && !oe1 && we1) ? mem1[a1[7:0]] : 16'hzzzz;
   assign dq3 = (!ce3 && !oe3 && we3) ? mem3[a3[7:0]] : 16'hzzzz;
   always @(posedge clk) begin
      if (!ce1 && !we1) begin
         if (!lb1) mem1[a1[7:0]][7:0]  <= dq1[7:0];
         if (!ub1) mem1[a1[7:0]][15:8] <= dq1[15:8];
      end
      if (!ce3 && !we3) begin
         if (!lb3) mem3[a3[7:0]][7:0]  <= dq3[7:0];
         if (!ub3) mem3[a3[7:0]][15:8] <= dq3[15:8];
      end
   end

   wire        obs_rdy   = use3 ? bus3.o_rdy   : bus1.o_rdy;
   wire        obs_done  = use3 ? bus3.o_done  : bus1.o_done;
   wire [31:0] obs_rdata = use3 ? bus3.o_rdata : bus1.o_rdata;
   wire        obs_ce    = use3 ? ce3 : ce1;
   wire        obs_we    = use3 ? we3 : we1;
   wire        obs_lb    = use3 ? lb3 : lb1;
   wire        obs_ub    = use3 ? ub3 : ub1;
   wire [17:0] obs_addr  = use3 ? a3  : a1;
   wire        obs_dqoe  = use3 ? dut3.dq_oe : dut1.dq_oe;

   int acc1 = 0;
   int done1 = 0;
   always @(posedge clk) begin
      if (bus1.i_req && bus1.o_rdy) acc1 <= acc1 + 1;
      if (bus1.o_done) done1 <= done1 + 1;
   end

   int total = 0;
   int bad   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Results of the last run_req call.
   int          lat, we_low, ce_low, we_run, we_run_max, margin_err;
   bit          to, rdy_busy;
   logic        lb_at_we, ub_at_we, dqoe_at_done, ce_at_done;
   logic [17:0] addr_at_we;

   // Issue one request and watch the pins until o_done (bounded).
   task automatic run_req(input bit d3, input bit w, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] m, input bit keep);
      int n;
      logic p_we, p_ce, p_lb, p_ub;
      logic [17:0] p_addr;
      use3 = d3; we = w; addr = a; wdata = d; bmask = m; req = 1'b1;
      lat = 0; we_low = 0; ce_low = 0; we_run = 0; we_run_max = 0; margin_err = 0;
      to = 1'b0; rdy_busy = 1'b0; lb_at_we = 1'b1; ub_at_we = 1'b1; addr_at_we = '0;
      dqoe_at_done = 1'b1; ce_at_done = 1'b0;
      n = 0;
      while (!obs_rdy && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!obs_rdy) begin
         to = 1'b1;
      end else begin
         @(posedge clk);
         #1;
         if (!keep) req = 1'b0;
         p_we = 1'b1; p_ce = 1'b1; p_lb = 1'b1; p_ub = 1'b1; p_addr = obs_addr;
         while (lat < 60) begin
            @(negedge clk);
            lat++;
            if (obs_done) break;
            if (obs_rdy) rdy_busy = 1'b1;
            if (!obs_ce) ce_low++;
            if (!obs_we) begin
               we_low++;
               we_run++;
               if (we_run > we_run_max) we_run_max = we_run;
               lb_at_we = obs_lb; ub_at_we = obs_ub; addr_at_we = obs_addr;
            end else begin
               we_run = 0;
            end
            if (p_we && !obs_we && (p_ce || p_addr !== obs_addr || p_lb !== obs_lb || p_ub !== obs_ub))
               margin_err++;
            if (!p_we && obs_we && (obs_ce || p_addr !== obs_addr || p_lb !== obs_lb || p_ub !== obs_ub))
               margin_err++;
            p_we = obs_we; p_ce = obs_ce; p_lb = obs_lb; p_ub = obs_ub; p_addr = obs_addr;
         end
         if (!obs_done) to = 1'b1;
         dqoe_at_done = obs_dqoe;
         ce_at_done   = obs_ce;
      end
   endtask

   initial begin
      int d;
      int acc0, done0;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_rdy",   32'(bus1.o_rdy), 32'd0);
      check("rst_done",  32'(bus1.o_done), 32'd0);
      check("rst_rdata", bus1.o_rdata, 32'h0);
      check("rst_addr",  32'(a1), 32'h0);
      check("rst_strb",  32'({ce1, we1, oe1, lb1, ub1}), 32'h1F);
      check("rst_dqoe",  32'(dut1.dq_oe), 32'd0);
      rst = 1'b0;
      #1;
      check("rst_rel_rdy", 32'(bus1.o_rdy), 32'd1);
      @(negedge clk);

      // Full write 0xDEADBEEF @0x40
      run_req(1'b0, 1'b1, 32'h40, 32'hDEADBEEF, 4'hF, 1'b0);
      check("wr1_to",      32'(to), 32'd0);
      check("wr1_lat",     32'(lat), 32'd7);
      check("wr1_we_low",  32'(we_low), 32'd2);
      check("wr1_margin",  32'(margin_err), 32'd0);
      check("wr1_busy",    32'(rdy_busy), 32'd0);
      check("wr1_lanes",   32'({lb_at_we, ub_at_we}), 32'd0);
      check("wr1_mem_lo",  32'(mem1[8'h20]), 32'hBEEF);
      check("wr1_mem_hi",  32'(mem1[8'h21]), 32'hDEAD);
      check("wr1_done_rel", 32'({ce_at_done, dqoe_at_done}), 32'b10);

      // Read back
      run_req(1'b0, 1'b0, 32'h40, 32'h0, 4'h0, 1'b0);
      check("rd1_lat",    32'(lat), 32'd5);
      check("rd1_rdata",  obs_rdata, 32'hDEADBEEF);
      check("rd1_we_low", 32'(we_low), 32'd0);
      check("rd1_busy",   32'(rdy_busy), 32'd0);
      @(negedge clk);
      check("rd1_hold",   obs_rdata, 32'hDEADBEEF);

      // Single-byte write to byte 2: only the HI phase runs
      run_req(1'b0, 1'b1, 32'h40, 32'h11223344, 4'b0100, 1'b0);
      check("wr2_lat",    32'(lat), 32'd4);
      check("wr2_we_low", 32'(we_low), 32'd1);
      check("wr2_ce_low", 32'(ce_low), 32'd3);
      check("wr2_lanes",  32'({lb_at_we, ub_at_we}), 32'b01);
      check("wr2_addr",   32'(addr_at_we), 32'h21);
      check("wr2_margin", 32'(margin_err), 32'd0);
      run_req(1'b0, 1'b0, 32'h40, 32'h0, 4'hF, 1'b0);
      check("rd2_rdata",  obs_rdata, 32'hDE22BEEF);

      // Mask-0 write never touches SRAM
      run_req(1'b0, 1'b1, 32'h40, 32'hFFFFFFFF, 4'b0000, 1'b0);
      check("wr0_lat",    32'(lat), 32'd1);
      check("wr0_ce_low", 32'(ce_low), 32'd0);
      check("wr0_mem",    32'({mem1[8'h21], mem1[8'h20]}), 32'hDE22BEEF);

      // i_req held high across alternating write/read
      @(negedge clk);
      acc0 = acc1; done0 = done1;
      run_req(1'b0, 1'b1, 32'h100, 32'hCAFEF00D, 4'hF, 1'b1);
      check("bb_wr_a_lat",  32'(lat), 32'd7);
      check("bb_wr_a_busy", 32'(rdy_busy), 32'd0);
      run_req(1'b0, 1'b0, 32'h100, 32'h0, 4'h0, 1'b1);
      check("bb_rd_a_lat",  32'(lat), 32'd5);
      check("bb_rd_a_data", obs_rdata, 32'hCAFEF00D);
      check("bb_rd_a_busy", 32'(rdy_busy), 32'd0);
      run_req(1'b0, 1'b1, 32'h100, 32'h0BADBEEF, 4'b1001, 1'b1);
      check("bb_wr_b_lat",  32'(lat), 32'd7);
      run_req(1'b0, 1'b0, 32'h100, 32'h0, 4'h0, 1'b1);
      req = 1'b0;
      check("bb_rd_b_data", obs_rdata, 32'h0BFEF0EF);
      check("bb_rd_b_busy", 32'(rdy_busy), 32'd0);
      @(negedge clk);
      check("bb_accepts",   32'(acc1 - acc0), 32'd4);
      check("bb_dones",     32'(done1 - done0), 32'd4);

      // Reset during LO_ACT of a write
      done0 = done1;
      use3 = 1'b0; we = 1'b1; addr = 32'h80; wdata = 32'hAAAA5555; bmask = 4'hF; req = 1'b1;
      @(posedge clk);
      #1;
      req = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("mr_in_act",    32'(we1), 32'd0);
      rst = 1'b1;
      @(negedge clk);
      check("mr_strb",      32'({ce1, we1, oe1, lb1, ub1}), 32'h1F);
      check("mr_dqoe",      32'(dut1.dq_oe), 32'd0);
      check("mr_addr",      32'(a1), 32'h0);
      check("mr_rdata",     bus1.o_rdata, 32'h0);
      check("mr_rdy_in_rst", 32'(bus1.o_rdy), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      check("mr_rdy_after", 32'(bus1.o_rdy), 32'd1);
      d = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (bus1.o_done) d++;
      end
      check("mr_no_done",   32'(d + (done1 - done0)), 32'd0);

      // T_PULSE = 3 instance
      run_req(1'b1, 1'b1, 32'h40, 32'h12345678, 4'hF, 1'b0);
      check("t3_wr_to",     32'(to), 32'd0);
      check("t3_wr_lat",    32'(lat), 32'd11);
      check("t3_we_run",    32'(we_run_max), 32'd3);
      check("t3_we_low",    32'(we_low), 32'd6);
      check("t3_margin",    32'(margin_err), 32'd0);
      check("t3_mem",       32'({mem3[8'h21], mem3[8'h20]}), 32'h12345678);
      run_req(1'b1, 1'b0, 32'h40, 32'h0, 4'h0, 1'b0);
      check("t3_rd_lat",    32'(lat), 32'd9);
      check("t3_rd_data",   obs_rdata, 32'h12345678);
      check("t3_rd_busy",   32'(rdy_busy), 32'd0);

      repeat (2) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
